// File: rtl/l1_direct_mapped_cache_if.sv
// l1_direct_mapped_cache_if
// ---------------------------------------------------------------------------
// Bundles the two buses around the L1 cache: the CPU word port and the
// physical-memory line port.
//   CPU side    : mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
//                 (requests) and mem_rdata, mem_resp (completion).
//   Memory side : pmem_address, pmem_read, pmem_write, pmem_wdata (line
//                 requests) and pmem_rdata, pmem_resp (memory completion).
// Modports:
//   slave  - the cache itself: consumes CPU requests and memory responses.
//   master - the environment around the cache (CPU plus physical memory):
//            issues CPU requests and answers line transfers.
interface l1_direct_mapped_cache_if;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;

    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_direct_mapped_cache.sv
// l1_direct_mapped_cache
// ---------------------------------------------------------------------------
// Write-back, write-allocate, direct-mapped L1 cache between the multicycle
// RV32I memory port and physical memory. 32-byte lines, register-based tag,
// valid, dirty and data arrays.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears valid/dirty, FSM to IDLE)
//   bus   - l1_direct_mapped_cache_if.slave: CPU word port and 256-bit
//           physical-memory line port
// Address split: tag = addr[31:5+IDX], index = addr[4+IDX:5], word = addr[4:2].
module l1_direct_mapped_cache #(
    parameter int SETS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    l1_direct_mapped_cache_if.slave bus
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 27 - IDX;

    typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, FILL} state_t;

    state_t state;
    state_t state_next;

    logic [TAG-1:0] tag_array  [SETS];
    logic [255:0]   data_array [SETS];
    logic [SETS-1:0] valid;
    logic [SETS-1:0] dirty;
    logic [31:0]     rdata_q;

    logic [TAG-1:0] tag;
    logic [IDX-1:0] index;
    logic [2:0]     word;
    logic           request;
    logic           is_write;
    logic           hit;
    logic           unused_addr_bits;

    assign tag   = bus.mem_address[31:5+IDX];
    assign index = bus.mem_address[4+IDX:5];
    assign word  = bus.mem_address[4:2];

    // Byte offset within the word is irrelevant to a word-wide port.
    assign unused_addr_bits = ^bus.mem_address[1:0];

    // A simultaneous read and write is handled as a write.
    assign request  = bus.mem_read | bus.mem_write;
    assign is_write = bus.mem_write;
    assign hit      = valid[index] && (tag_array[index] == tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // After a fill the FSM returns to IDLE rather than RESP so the held
    // request is looked up again and completes through the ordinary hit path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        state_next = RESP;
                    end else if (valid[index] && dirty[index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            RESP:      state_next = IDLE;
            WRITEBACK: if (bus.pmem_resp) state_next = FILL;
            FILL:      if (bus.pmem_resp) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs depend only on the state register, so a reset forces every
    // request line low immediately without waiting for a clock.
    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        case (state)
            RESP: bus.mem_resp = 1'b1;
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_array[index], index, 5'b0};
                bus.pmem_wdata   = data_array[index];
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag, index, 5'b0};
            end
            default: ;
        endcase
    end

    assign bus.mem_rdata = rdata_q;

    // Line status bits and the read-data register; these are the only
    // storage that must come out of reset in a known state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            dirty   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && hit) begin
                        if (is_write) begin
                            if (|bus.mem_byte_enable) begin
                                dirty[index] <= 1'b1;
                            end
                        end else begin
                            rdata_q <= data_array[index][32*int'(word) +: 32];
                        end
                    end
                end
                WRITEBACK: if (bus.pmem_resp) dirty[index] <= 1'b0;
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset. A reset holds the FSM in IDLE with
    // every line invalid, so neither branch below can fire during reset and
    // an abandoned fill never updates a line.
    always_ff @(posedge clk) begin
        if (state == IDLE && request && hit && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_byte_enable[i]) begin
                    data_array[index][32*int'(word) + 8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end else if (state == FILL && bus.pmem_resp) begin
            data_array[index] <= bus.pmem_rdata;
            tag_array[index]  <= tag;
        end
    end
endmodule
